// File: rtl/partial_sum_layer7.sv
// -----------------------------------------------------------------------------
// partial_sum_layer7
//
// Per-channel partial-sum accumulator for layer 7. It sits directly upstream of
// the layer-7 BN/residual stage. The CIM macro hands over one signed partial
// result per channel per valid beat. This block sums PARTIAL_NUM valid beats
// into one output pixel, reduces the sum to DATA_WIDTH and presents it with a
// one-cycle data_e strobe.
//
// Optional feature macro: PS_SATURATE_EN
//   defined   : the group sum saturates to the signed DATA_WIDTH range
//   undefined : the group sum wraps to its low DATA_WIDTH bits
//               (no saturation comparators are built)
//
// Ports
//   clk          in   system clock (single clock domain)
//   rst_n        in   asynchronous active-low reset
//   mode         in   0 = reload parameters (block idle/cleared), 1 = calculate
//   frame_start  in   one-cycle pulse realigning the group at feature-map start
//   ps_in[C]     in   signed PS_WIDTH macro partial results, one per channel
//   ps_e         in   ps_in valid this cycle
//   data_out[C]  out  signed DATA_WIDTH registered group sums (BN data_in)
//   data_e       out  one-cycle strobe marking data_out as new
//   group_cnt    out  beats accumulated so far in the current group
// -----------------------------------------------------------------------------
module partial_sum_layer7 #(
  parameter int CHANNEL_NUM = 'd512,
  parameter int PS_WIDTH    = 'd10,
  parameter int DATA_WIDTH  = 'd16,
  parameter int PARTIAL_NUM = 'd9,
  parameter int ACC_WIDTH   = DATA_WIDTH * 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         mode,
  input  logic                         frame_start,
  input  logic signed [PS_WIDTH-1:0]   ps_in    [CHANNEL_NUM],
  input  logic                         ps_e,
  output logic signed [DATA_WIDTH-1:0] data_out [CHANNEL_NUM],
  output logic                         data_e,
  output logic [7:0]                   group_cnt
);

  localparam logic       CALCULATE = 1'b1;
  localparam logic [7:0] LAST_CNT  = 8'(PARTIAL_NUM - 1);

`ifdef PS_SATURATE_EN
  // Bounds of the signed DATA_WIDTH range, expressed at accumulator width.
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
`endif

  // Reduce a full-width group sum to the output width.
  function automatic logic signed [DATA_WIDTH-1:0] reduce(
    input logic signed [ACC_WIDTH-1:0] s
  );
`ifdef PS_SATURATE_EN
    if (s > SAT_MAX) begin
      reduce = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (s < SAT_MIN) begin
      reduce = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      reduce = DATA_WIDTH'(s);
    end
`else
    reduce = DATA_WIDTH'(s);
`endif
  endfunction

  // Sign-extend one macro partial result to accumulator width.
  function automatic logic signed [ACC_WIDTH-1:0] ext(
    input logic signed [PS_WIDTH-1:0] p
  );
    ext = {{(ACC_WIDTH-PS_WIDTH){p[PS_WIDTH-1]}}, p};
  endfunction

  logic [7:0]                   cnt_q,    cnt_d;
  logic                         data_e_q, data_e_d;
  logic signed [ACC_WIDTH-1:0]  acc_q    [CHANNEL_NUM];
  logic signed [ACC_WIDTH-1:0]  acc_d    [CHANNEL_NUM];
  logic signed [DATA_WIDTH-1:0] data_q   [CHANNEL_NUM];
  logic signed [DATA_WIDTH-1:0] data_d   [CHANNEL_NUM];
  logic signed [ACC_WIDTH-1:0]  ext_w    [CHANNEL_NUM];
  logic signed [ACC_WIDTH-1:0]  sum_w    [CHANNEL_NUM];

  // Per-channel extended input and running sum including this beat.
  always_comb begin
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      ext_w[i] = ext(ps_in[i]);
      sum_w[i] = acc_q[i] + ext_w[i];
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    data_e_d = 1'b0;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      acc_d[i]  = acc_q[i];
      data_d[i] = data_q[i];
    end

    if (mode != CALCULATE) begin
      // Parameter reload: drop any group in progress, keep the last result.
      cnt_d = 8'd0;
      for (int i = 0; i < CHANNEL_NUM; i++) begin
        acc_d[i] = '0;
      end
    end else if (frame_start) begin
      // Realign: the partial group is discarded silently; a concurrent beat
      // becomes the first beat of the new group (or the whole group when
      // PARTIAL_NUM is 1).
      if (ps_e && (PARTIAL_NUM == 1)) begin
        cnt_d    = 8'd0;
        data_e_d = 1'b1;
        for (int i = 0; i < CHANNEL_NUM; i++) begin
          acc_d[i]  = '0;
          data_d[i] = reduce(ext_w[i]);
        end
      end else if (ps_e) begin
        cnt_d = 8'd1;
        for (int i = 0; i < CHANNEL_NUM; i++) begin
          acc_d[i] = ext_w[i];
        end
      end else begin
        cnt_d = 8'd0;
        for (int i = 0; i < CHANNEL_NUM; i++) begin
          acc_d[i] = '0;
        end
      end
    end else if (ps_e) begin
      if (cnt_q == LAST_CNT) begin
        // Last beat: publish the reduced sum and restart with no bubble.
        cnt_d    = 8'd0;
        data_e_d = 1'b1;
        for (int i = 0; i < CHANNEL_NUM; i++) begin
          acc_d[i]  = '0;
          data_d[i] = reduce(sum_w[i]);
        end
      end else begin
        cnt_d = cnt_q + 8'd1;
        for (int i = 0; i < CHANNEL_NUM; i++) begin
          acc_d[i] = sum_w[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= 8'd0;
      data_e_q <= 1'b0;
      for (int i = 0; i < CHANNEL_NUM; i++) begin
        acc_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      cnt_q    <= cnt_d;
      data_e_q <= data_e_d;
      for (int i = 0; i < CHANNEL_NUM; i++) begin
        acc_q[i]  <= acc_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  assign data_e    = data_e_q;
  assign group_cnt = cnt_q;

  always_comb begin
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      data_out[i] = data_q[i];
    end
  end

endmodule

// File: tb/tb_partial_sum_layer7.sv
module tb_partial_sum_layer7;

  localparam int NCH = 4;
  localparam int PSW = 10;
  localparam int DW  = 16;

  logic clk = 1'b0;
  logic rst_n, mode, frame_start;

  logic signed [PSW-1:0] ps_in_m  [NCH];
  logic                  ps_e_m;
  logic signed [DW-1:0]  data_m   [NCH];
  logic                  data_e_m;
  logic [7:0]            gcnt_m;

  logic signed [PSW-1:0] ps_in_a  [2];
  logic                  ps_e_a;
  logic signed [DW-1:0]  data_a   [2];
  logic                  data_e_a;
  logic [7:0]            gcnt_a;

  logic signed [PSW-1:0] ps_in_b  [2];
  logic                  ps_e_b;
  logic signed [DW-1:0]  data_b   [2];
  logic                  data_e_b;
  logic [7:0]            gcnt_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  partial_sum_layer7 #(.CHANNEL_NUM(NCH), .PS_WIDTH(PSW), .DATA_WIDTH(DW),
                       .PARTIAL_NUM(9)) u_dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .frame_start(frame_start),
    .ps_in(ps_in_m), .ps_e(ps_e_m), .data_out(data_m), .data_e(data_e_m),
    .group_cnt(gcnt_m));

  partial_sum_layer7 #(.CHANNEL_NUM(2), .PS_WIDTH(PSW), .DATA_WIDTH(DW),
                       .PARTIAL_NUM(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .frame_start(frame_start),
    .ps_in(ps_in_a), .ps_e(ps_e_a), .data_out(data_a), .data_e(data_e_a),
    .group_cnt(gcnt_a));

  partial_sum_layer7 #(.CHANNEL_NUM(2), .PS_WIDTH(PSW), .DATA_WIDTH(DW),
                       .PARTIAL_NUM(65)) u_dut65 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .frame_start(frame_start),
    .ps_in(ps_in_b), .ps_e(ps_e_b), .data_out(data_b), .data_e(data_e_b),
    .group_cnt(gcnt_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = 1'b0; frame_start = 1'b0;
    ps_e_m = 1'b0; ps_e_a = 1'b0; ps_e_b = 1'b0;
    for (int i = 0; i < NCH; i++) ps_in_m[i] = '0;
    for (int i = 0; i < 2; i++) begin ps_in_a[i] = '0; ps_in_b[i] = '0; end
    tick(); tick();
    n_vec++;
    if (data_e_m !== 1'b0) begin n_err++; $display("FAIL reset data_e: got %b want 0", data_e_m); end
    n_vec++;
    if (gcnt_m !== 8'd0) begin n_err++; $display("FAIL reset group_cnt: got %0d want 0", gcnt_m); end
    for (int i = 0; i < NCH; i++) begin
      n_vec++;
      if (data_m[i] !== 16'sd0) begin n_err++; $display("FAIL reset data_out[%0d]: got %0d want 0", i, data_m[i]); end
    end
    @(negedge clk);
    rst_n = 1'b1; mode = 1'b1;
  endtask

  task automatic test_back_to_back();
    int want;
    for (int i = 0; i < NCH; i++) ps_in_m[i] = PSW'(3 * (i + 1));
    ps_e_m = 1'b1;
    for (int c = 1; c <= 27; c++) begin
      tick();
      n_vec++;
      if (data_e_m !== ((c % 9) == 0)) begin
        n_err++; $display("FAIL b2b data_e beat %0d: got %b want %b", c, data_e_m, (c % 9) == 0);
      end
      n_vec++;
      if (gcnt_m !== 8'(c % 9)) begin
        n_err++; $display("FAIL b2b group_cnt beat %0d: got %0d want %0d", c, gcnt_m, c % 9);
      end
      if ((c % 9) == 0) begin
        for (int i = 0; i < NCH; i++) begin
          want = 27 * (i + 1);
          n_vec++;
          if (data_m[i] !== 16'(want)) begin
            n_err++; $display("FAIL b2b data_out[%0d] beat %0d: got %0d want %0d", i, c, data_m[i], want);
          end
        end
      end
    end
    ps_e_m = 1'b0;
    tick();
    n_vec++;
    if (data_e_m !== 1'b0) begin n_err++; $display("FAIL b2b data_e after stop: got %b want 0", data_e_m); end
  endtask

  task automatic test_reset_mid_group();
    for (int i = 0; i < NCH; i++) ps_in_m[i] = 10'sd1;
    ps_e_m = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    ps_e_m = 1'b0;
    n_vec++;
    if (gcnt_m !== 8'd4) begin n_err++; $display("FAIL rstmid pre group_cnt: got %0d want 4", gcnt_m); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (gcnt_m !== 8'd0) begin n_err++; $display("FAIL rstmid async group_cnt: got %0d want 0", gcnt_m); end
    for (int i = 0; i < NCH; i++) begin
      n_vec++;
      if (data_m[i] !== 16'sd0) begin n_err++; $display("FAIL rstmid async data_out[%0d]: got %0d want 0", i, data_m[i]); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    ps_e_m = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      n_vec++;
      if (data_e_m !== (c == 9)) begin n_err++; $display("FAIL rstmid data_e beat %0d: got %b want %b", c, data_e_m, c == 9); end
    end
    for (int i = 0; i < NCH; i++) begin
      n_vec++;
      if (data_m[i] !== 16'sd9) begin n_err++; $display("FAIL rstmid data_out[%0d]: got %0d want 9", i, data_m[i]); end
    end
    ps_e_m = 1'b0;
    tick();
    n_vec++;
    if (data_e_m !== 1'b0) begin n_err++; $display("FAIL rstmid data_e width: got %b want 0", data_e_m); end
  endtask

  task automatic test_gapped();
    int gaps [9] = '{0, 2, 1, 0, 3, 0, 1, 2, 0};
    int want;
    for (int i = 0; i < NCH; i++) ps_in_m[i] = PSW'(-5 - i);
    for (int b = 0; b < 9; b++) begin
      ps_e_m = 1'b0;
      for (int g = 0; g < gaps[b]; g++) begin
        tick();
        n_vec++;
        if (data_e_m !== 1'b0) begin n_err++; $display("FAIL gap data_e idle before beat %0d: got %b want 0", b, data_e_m); end
      end
      ps_e_m = 1'b1;
      tick();
      n_vec++;
      if (data_e_m !== (b == 8)) begin n_err++; $display("FAIL gap data_e beat %0d: got %b want %b", b, data_e_m, b == 8); end
    end
    ps_e_m = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      want = 9 * (-5 - i);
      n_vec++;
      if (data_m[i] !== 16'(want)) begin n_err++; $display("FAIL gap data_out[%0d]: got %0d want %0d", i, data_m[i], want); end
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_vec++;
      if (data_e_m !== 1'b0) begin n_err++; $display("FAIL gap data_e after: got %b want 0", data_e_m); end
      n_vec++;
      if (data_m[0] !== -16'sd45) begin n_err++; $display("FAIL gap data_out hold: got %0d want -45", data_m[0]); end
    end
  endtask

  task automatic test_frame_collision();
    int want;
    for (int i = 0; i < NCH; i++) ps_in_m[i] = 10'sd1;
    ps_e_m = 1'b1;
    for (int c = 0; c < 8; c++) tick();
    n_vec++;
    if (gcnt_m !== 8'd8) begin n_err++; $display("FAIL fs pre group_cnt: got %0d want 8", gcnt_m); end
    for (int i = 0; i < NCH; i++) ps_in_m[i] = PSW'(7 + i);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n_vec++;
    if (data_e_m !== 1'b0) begin n_err++; $display("FAIL fs collision data_e: got %b want 0", data_e_m); end
    n_vec++;
    if (gcnt_m !== 8'd1) begin n_err++; $display("FAIL fs collision group_cnt: got %0d want 1", gcnt_m); end
    n_vec++;
    if (data_m[0] !== -16'sd45) begin n_err++; $display("FAIL fs collision data_out hold: got %0d want -45", data_m[0]); end
    for (int i = 0; i < NCH; i++) ps_in_m[i] = 10'sd1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      n_vec++;
      if (data_e_m !== (c == 8)) begin n_err++; $display("FAIL fs next data_e beat %0d: got %b want %b", c, data_e_m, c == 8); end
    end
    ps_e_m = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      want = 15 + i;
      n_vec++;
      if (data_m[i] !== 16'(want)) begin n_err++; $display("FAIL fs next data_out[%0d]: got %0d want %0d", i, data_m[i], want); end
    end
  endtask

  task automatic test_mode_drop();
    for (int i = 0; i < NCH; i++) ps_in_m[i] = 10'sd4;
    ps_e_m = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    mode = 1'b0;
    tick();
    n_vec++;
    if (data_e_m !== 1'b0) begin n_err++; $display("FAIL mode low data_e: got %b want 0", data_e_m); end
    n_vec++;
    if (gcnt_m !== 8'd0) begin n_err++; $display("FAIL mode low group_cnt: got %0d want 0", gcnt_m); end
    n_vec++;
    if (data_m[1] !== 16'sd16) begin n_err++; $display("FAIL mode low data_out hold: got %0d want 16", data_m[1]); end
    mode = 1'b1;
    for (int i = 0; i < NCH; i++) ps_in_m[i] = 10'sd2;
    for (int c = 1; c <= 9; c++) begin
      tick();
      n_vec++;
      if (data_e_m !== (c == 9)) begin n_err++; $display("FAIL mode next data_e beat %0d: got %b want %b", c, data_e_m, c == 9); end
    end
    ps_e_m = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      n_vec++;
      if (data_m[i] !== 16'sd18) begin n_err++; $display("FAIL mode next data_out[%0d]: got %0d want 18", i, data_m[i]); end
    end
  endtask

  task automatic test_saturation();
    logic signed [DW-1:0] want0, want1;
    ps_in_a[0] = 10'sd511; ps_in_a[1] = -10'sd512;
    ps_e_a = 1'b1;
    for (int c = 1; c <= 64; c++) begin
      tick();
      if (c >= 63) begin
        n_vec++;
        if (data_e_a !== (c == 64)) begin n_err++; $display("FAIL sat64 data_e beat %0d: got %b want %b", c, data_e_a, c == 64); end
      end
    end
    ps_e_a = 1'b0;
    n_vec++;
    if (data_a[0] !== 16'sd32704) begin n_err++; $display("FAIL sat64 data_out[0]: got %0d want 32704", data_a[0]); end
    n_vec++;
    if (data_a[1] !== -16'sd32768) begin n_err++; $display("FAIL sat64 data_out[1]: got %0d want -32768", data_a[1]); end

`ifdef PS_SATURATE_EN
    want0 = 16'h7fff;
    want1 = 16'h8000;
`else
    want0 = -16'sd32321;
    want1 = 16'sd32256;
`endif
    ps_in_b[0] = 10'sd511; ps_in_b[1] = -10'sd512;
    ps_e_b = 1'b1;
    for (int c = 1; c <= 65; c++) begin
      tick();
      if (c >= 64) begin
        n_vec++;
        if (data_e_b !== (c == 65)) begin n_err++; $display("FAIL sat65 data_e beat %0d: got %b want %b", c, data_e_b, c == 65); end
      end
    end
    ps_e_b = 1'b0;
    n_vec++;
    if (data_b[0] !== want0) begin n_err++; $display("FAIL sat65 data_out[0]: got %0d want %0d", data_b[0], want0); end
    n_vec++;
    if (data_b[1] !== want1) begin n_err++; $display("FAIL sat65 data_out[1]: got %0d want %0d", data_b[1], want1); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_reset_mid_group();
    test_gapped();
    test_frame_collision();
    test_mode_drop();
    test_saturation();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/partial_sum_layer7.md
# partial_sum_layer7

Per-channel partial-sum accumulator for layer 7, directly upstream of the layer-7 BN/residual stage.

- The CIM macro delivers one partial result per channel per beat. This block sums `PARTIAL_NUM` consecutive valid beats per output pixel.
- At the end of each group it reduces the sum to `DATA_WIDTH`.
- It presents the result with a one-cycle `data_e` strobe, in the `data_in`/`data_e` form the BN stage consumes.

## Interface
Parameters:
- `CHANNEL_NUM`, default 'd512: number of channels (macro columns).
- `PS_WIDTH`, default 'd10: signed width of each macro partial result.
- `PARTIAL_NUM`, default 'd9: beats per group (3x3 kernel positions). Legal range is 1..255.
- `ACC_WIDTH`, default `DATA_WIDTH*2`: internal signed accumulator width.

Ports:
- `clk`, input, 1: system clock. This is the only clock.
- `rst_n`, input, 1: asynchronous active-low reset. Value is `RSTVALID`.
- `mode`, input, 1: LOW means reload parameters, HIGH means calculate. Encoding is `CALCULATE`.
- `frame_start`, input, 1: one-cycle pulse that realigns the group counter at the start of a feature map.
- `ps_in[CHANNEL_NUM]`, input, signed `PS_WIDTH` each: macro partial results.
- `ps_e`, input, 1: `ps_in` is valid this cycle.
- `data_out[CHANNEL_NUM]`, output, signed `DATA_WIDTH` each: registered group sums. Goes to the BN stage `data_in`.
- `data_e`, output, 1: one-cycle strobe marking `data_out` as new.
- `group_cnt`, output, 8: beats accumulated so far in the current group (0..PARTIAL_NUM-1).

## Operation
- State is a beat counter `cnt` plus `CHANNEL_NUM` accumulators `acc[i]`.
- Each `ps_in[i]` is sign-extended to `ACC_WIDTH` before it is added.
- The states are ACCUM(cnt = k), for k from 0 to PARTIAL_NUM-1.

Per-cycle update, in priority order:
1. **`mode` LOW:**
   - `cnt` and `acc` are cleared to 0.
   - `data_e` is 0.
   - `data_out` holds its value.
   - `ps_e` and `frame_start` are ignored.
2. **`frame_start` HIGH:** the group restarts.
   - With `ps_e` high: `acc <= ext(ps_in)` and `cnt <= 1`. This beat is the first beat of the new group.
   - With `ps_e` low: `acc <= 0` and `cnt <= 0`.
   - Any partial group in progress is discarded without a strobe.
   - If `PARTIAL_NUM` = 1 and `ps_e` is high, the group completes immediately, as in rule 3.
3. **`ps_e` HIGH and `cnt` = PARTIAL_NUM-1 (last beat):**
   - `data_out[i] <= reduce(acc[i] + ext(ps_in[i]))`.
   - `acc <= 0` and `cnt <= 0`.
   - `data_e <= 1`.
4. **`ps_e` HIGH, other `cnt` values:**
   - `acc <= acc + ext(ps_in)` and `cnt <= cnt + 1`.
5. **`ps_e` LOW:** `acc` and `cnt` hold.

Additional rules:
- `data_e <= 0` in every case other than rule 3.
- Gaps between `ps_e` beats are allowed anywhere within a group.
- `reduce()` is defined under Configuration.
- `ACC_WIDTH` ≥ `PS_WIDTH` + 8, so the accumulator never overflows for any legal `PARTIAL_NUM`.

## Timing
- Reset values: all `data_out` = 0, `data_e` = 0, `group_cnt` = 0, all `acc` = 0.
- Reset is asynchronous on assertion. If it occurs mid-group, the group is lost.
- Latency: `data_out` and `data_e` are valid one cycle after the clock edge that samples the last beat.
- `data_out` holds until the next completed group, so the downstream stage may sample it at any time while `data_e` is high.
- Back-to-back groups have no bubble. With `ps_e` held high, `data_e` pulses once every `PARTIAL_NUM` cycles.
- Simultaneous `frame_start` and last beat: `frame_start` wins and no strobe is issued.
- `mode` falling mid-group discards the group. The first beat after `mode` returns HIGH starts at `cnt` = 0.

## Configuration
- Macro name: `PS_SATURATE_EN`.
- **Defined:** `reduce()` saturates to the signed `DATA_WIDTH` range.
  - Sums above 32767 become 16'h7fff.
  - Sums below -32768 become 16'h8000.
  - All other sums are passed as their low `DATA_WIDTH` bits.
- **Undefined:** `reduce()` truncates to the low `DATA_WIDTH` bits (two's-complement wrap). The saturation comparators are not built.

## Test plan
- **Reset mid-group:** assert `rst_n` low after 4 beats. Required response: all outputs go to 0 immediately. After release, 9 beats of +1 give `data_out` = 9 with a single `data_e` pulse.
- **Back-to-back groups:** hold `ps_e` high for 27 cycles with `ps_in` = 3 on all channels. Required response: `data_e` pulses on cycles 10, 19 and 28, and `data_out` = 27 each time.
- **Gapped beats:** 9 beats of -5 with random `ps_e` gaps. Required response: `data_out` = -45, `data_e` for exactly one cycle, and `data_out` held afterwards.
- **Saturation with `PS_SATURATE_EN`:** `PARTIAL_NUM` = 64 with `ps_in` = 511 gives sum 32704, which passes unchanged. With `ps_in` = -512, sum -32768 passes unchanged. A 65-beat 511 case with `PARTIAL_NUM` = 65 gives 16'h7fff. Without the macro, the 65-beat case gives the wrapped low 16 bits of 33215, i.e. -32321.
- **`frame_start` collision:** `frame_start` together with what would be beat 9. Required response: no strobe, `group_cnt` = 1, and the next group's result includes that beat.
- **Mode drop:** `mode` goes LOW after 5 beats, then HIGH. Required response: `data_e` stays 0 and the next 9 beats of 2 give exactly 18.
